// File: rtl/bp_be_fp_unbox_pipe_pkg.sv
// Shared types and constants for the FP unbox pipeline: register-file entry
// layout (tag + 65-bit recoded DP), recoded SP layout and canonical NaN images.
package bp_be_fp_unbox_pipe_pkg;

    typedef enum logic { e_bp_default_cfg = 1'b0 } bp_params_e;

    localparam int dword_width_gp  = 64;
    localparam int dp_exp_width_gp = 11;
    localparam int dp_sig_width_gp = 53;
    localparam int sp_exp_width_gp = 8;
    localparam int sp_sig_width_gp = 24;
    localparam int dp_rec_width_gp = 1 + (dp_exp_width_gp + 1) + (dp_sig_width_gp - 1);
    localparam int dpath_width_gp  = 1 + dp_rec_width_gp;

    // Exponent offset between recoded DP and recoded SP encodings
    localparam int fp_bias_adj_gp = (1 << dp_exp_width_gp) - (1 << sp_exp_width_gp);

    localparam logic [dword_width_gp-1:0] fp_canon_nan_sp_gp = 64'hFFFF_FFFF_7FC0_0000;
    localparam logic [dword_width_gp-1:0] fp_canon_nan_dp_gp = 64'h7FF8_0000_0000_0000;

    typedef enum logic { e_fp_dp = 1'b0, e_fp_sp = 1'b1 } bp_be_fp_tag_e;

    typedef struct packed {
        logic                         sign;
        logic [dp_exp_width_gp:0]     exp;
        logic [dp_sig_width_gp-2:0]   fract;
    } bp_hardfloat_rec_dp_s;

    typedef struct packed {
        logic                         sign;
        logic [sp_exp_width_gp:0]     exp;
        logic [sp_sig_width_gp-2:0]   fract;
    } bp_hardfloat_rec_sp_s;

    typedef struct packed {
        bp_be_fp_tag_e         tag;
        bp_hardfloat_rec_dp_s  rec;
    } bp_be_fp_reg_s;

endpackage

// File: rtl/bp_be_fp_rec_dp_to_sp.sv
// Combinational downconvert of a recoded DP value that holds an SP-representable
// number into the recoded SP encoding (exponent rebias, fraction truncation).
module bp_be_fp_rec_dp_to_sp
    import bp_be_fp_unbox_pipe_pkg::*;
(
    input  bp_hardfloat_rec_dp_s dp_rec,
    output bp_hardfloat_rec_sp_s sp_rec
);

    logic [2:0]  exp_code;
    logic        special;
    logic [11:0] exp_adj;
    logic        unused_bits;

    // Zero and inf/NaN classes keep their 3-bit class code; others are rebiased
    assign exp_code = dp_rec.exp[11:9];
    assign special  = (exp_code == 3'd0) || (exp_code >= 3'd6);
    assign exp_adj  = dp_rec.exp - 12'(fp_bias_adj_gp);

    assign sp_rec.sign  = dp_rec.sign;
    assign sp_rec.exp   = special ? {exp_code, dp_rec.exp[5:0]} : exp_adj[8:0];
    assign sp_rec.fract = dp_rec.fract[51:29];

    assign unused_bits = ^{exp_adj[11:9], dp_rec.fract[28:0]};

endmodule

// File: rtl/bp_be_fp_unbox_pipe.sv
// Two-stage recoded-FP to IEEE image converter with valid/ready and flush.
// Optional macro BP_BE_FP_UNBOX_CANON_NAN_EN replaces any NaN with the canonical NaN.
module bp_be_fp_unbox_pipe
    import bp_be_fp_unbox_pipe_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg
)(
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      flush_i,
    input  logic [dpath_width_gp-1:0] reg_i,
    input  logic                      v_i,
    output logic                      ready_and_o,
    output logic [dword_width_gp-1:0] raw_o,
    output logic                      v_o,
    input  logic                      ready_and_i
);

    if (bp_params_p != e_bp_default_cfg) begin : g_cfg_check
        $error("bp_be_fp_unbox_pipe: unsupported processor configuration");
    end

    function automatic logic [63:0] dp_to_ieee(input bp_hardfloat_rec_dp_s rec);
        logic        is_zero, is_special, is_inf, is_sub;
        logic [5:0]  shamt;
        logic [52:0] sig;
        logic [51:0] denorm;
        logic [10:0] exp_out;
        logic [51:0] fract_out;
        is_zero    = (rec.exp[11:9] == 3'b000);
        is_special = (rec.exp[11:10] == 2'b11);
        is_inf     = is_special & ~rec.exp[9];
        is_sub     = (rec.exp < 12'd1026);
        shamt      = 6'd1 - rec.exp[5:0];
        sig        = {1'b0, ~is_zero, rec.fract[51:1]};
        denorm     = 52'(sig >> shamt);
        exp_out    = (is_sub ? 11'd0 : rec.exp[10:0] - 11'd1025) | {11{is_special}};
        fract_out  = is_sub ? denorm : (is_inf ? 52'd0 : rec.fract);
        return {rec.sign, exp_out, fract_out};
    endfunction

    function automatic logic [31:0] sp_to_ieee(input bp_hardfloat_rec_sp_s rec);
        logic        is_zero, is_special, is_inf, is_sub;
        logic [4:0]  shamt;
        logic [23:0] sig;
        logic [22:0] denorm;
        logic [7:0]  exp_out;
        logic [22:0] fract_out;
        is_zero    = (rec.exp[8:6] == 3'b000);
        is_special = (rec.exp[8:7] == 2'b11);
        is_inf     = is_special & ~rec.exp[6];
        is_sub     = (rec.exp < 9'd130);
        shamt      = 5'd1 - rec.exp[4:0];
        sig        = {1'b0, ~is_zero, rec.fract[22:1]};
        denorm     = 23'(sig >> shamt);
        exp_out    = (is_sub ? 8'd0 : rec.exp[7:0] - 8'd129) | {8{is_special}};
        fract_out  = is_sub ? denorm : (is_inf ? 23'd0 : rec.fract);
        return {rec.sign, exp_out, fract_out};
    endfunction

    bp_be_fp_reg_s        in_reg;
    logic                 vld_p1, vld_p2;
    bp_be_fp_tag_e        tag_p1;
    bp_hardfloat_rec_dp_s rec_p1;
    bp_hardfloat_rec_sp_s sp_rec_p1;
    logic [63:0]          raw_next;
    logic [63:0]          raw_p2;
    logic                 accept, load_p2;

    assign in_reg      = reg_i;
    assign ready_and_o = ~flush_i & (~vld_p1 | ~vld_p2 | ready_and_i);
    assign accept      = v_i & ready_and_o;
    assign load_p2     = vld_p1 & (~vld_p2 | ready_and_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (accept)
                vld_p1 <= 1'b1;
            else if (load_p2)
                vld_p1 <= 1'b0;
            if (load_p2)
                vld_p2 <= 1'b1;
            else if (ready_and_i)
                vld_p2 <= 1'b0;
        end
    end

    // ---- stage 1: capture tag/rec; SP downconvert from the registered value
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tag_p1 <= e_fp_dp;
            rec_p1 <= '0;
        end else if (accept) begin
            tag_p1 <= in_reg.tag;
            rec_p1 <= in_reg.rec;
        end
    end

    bp_be_fp_rec_dp_to_sp u_dp_to_sp (
        .dp_rec (rec_p1),
        .sp_rec (sp_rec_p1)
    );

    // ---- stage 2: recoded to IEEE, SP results NaN-boxed
    always_comb begin
        raw_next = (tag_p1 == e_fp_sp) ? {32'hFFFF_FFFF, sp_to_ieee(sp_rec_p1)}
                                       : dp_to_ieee(rec_p1);
`ifdef BP_BE_FP_UNBOX_CANON_NAN_EN
        if ((tag_p1 == e_fp_sp) && (sp_rec_p1.exp[8:6] == 3'b111))
            raw_next = fp_canon_nan_sp_gp;
        else if ((tag_p1 == e_fp_dp) && (rec_p1.exp[11:9] == 3'b111))
            raw_next = fp_canon_nan_dp_gp;
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            raw_p2 <= '0;
        else if (load_p2)
            raw_p2 <= raw_next;
    end

    assign raw_o = raw_p2;
    assign v_o   = vld_p2;

endmodule
